// File: rtl/hist_pkg.sv
// Shared types for the hit histogrammer: counter width, bin/trigger counts, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hist_pkg;

  localparam int HIST_W   = 32;
  localparam int NBINS    = 16;
  localparam int NTRIGOUT = 2;

  typedef logic [HIST_W-1:0] hist_cnt_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_COMMIT,
    S_DEAD
  } state_t;

endpackage

// File: rtl/hist_counter.sv
// 32-bit event counter with clear; clear and increment together load 1 (macro HIST_SATURATE_EN selects saturation).
// Latency: an increment is visible one cycle after inc is sampled.
// Backpressure: none; every inc pulse is counted (saturates or wraps at max).
module hist_counter
  import hist_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      clr,
  input  logic      inc,
  output hist_cnt_t count
);

  // Clear wins over the old value; an event in the clear cycle starts the new period at 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? hist_cnt_t'(1) : '0;
    end else if (inc) begin
`ifdef HIST_SATURATE_EN
      if (count != '1) begin
        count <= count + hist_cnt_t'(1);
      end
`else
      count <= count + hist_cnt_t'(1);
`endif
    end
  end

endmodule

// File: rtl/hit_histogrammer.sv
// Groups hit edges into coincidence windows, bins the OR-pattern into 16 counters, counts trigger-output edges.
// Latency: bin count visible two cycles after COMMIT is entered; trigger counts one cycle after the edge.
// Backpressure: none; edges arriving in COMMIT/DEAD are dropped by design. Optional macro: HIST_SATURATE_EN.
module hit_histogrammer
  import hist_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int WINDOW   = 4,
  parameter int DEADTIME = 2
)
(
  input  logic                clk,
  input  logic                reset,
  input  logic [NCH-1:0]      hits,
  input  logic                veto,
  input  logic [NTRIGOUT-1:0] trig_out,
  input  logic                resethist,
  output hist_cnt_t           h [NBINS],
  output hist_cnt_t           h_out [NTRIGOUT],
  output hist_cnt_t           nvetoed,
  output logic                busy
);

  localparam logic [7:0] WIN_LAST = 8'(WINDOW - 1);
  localparam logic [7:0] DEAD_LEN = 8'(DEADTIME);

  logic [NCH-1:0]      hits_d;
  logic [NTRIGOUT-1:0] trig_d;
  logic [NCH-1:0]      rise;
  logic [NTRIGOUT-1:0] trig_rise;

  state_t         state;
  state_t         state_nxt;
  logic [NCH-1:0] pat;
  logic           vetoseen;
  logic [7:0]     cnt;
  logic [7:0]     dcnt;

  logic [NBINS-1:0] commit_bin;
  logic             commit_veto;
  logic             busy_nxt;
  logic [NBINS-1:0] inc_bin;
  logic             inc_veto;

  assign rise      = hits & ~hits_d;
  assign trig_rise = trig_out & ~trig_d;

  // Previous-level registers for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      hits_d <= '0;
      trig_d <= '0;
    end else begin
      hits_d <= hits;
      trig_d <= trig_out;
    end
  end

  // FSM state register; reset abandons any window in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: window length counts the first-edge cycle, DEAD lasts DEADTIME cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (rise != '0) begin
          state_nxt = (WINDOW == 1) ? S_COMMIT : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (cnt == WIN_LAST) begin
          state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        state_nxt = (DEADTIME > 0) ? S_DEAD : S_IDLE;
      end
      S_DEAD: begin
        if (dcnt == DEAD_LEN) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Window accumulation: OR of edges, sticky veto, window and dead-time counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat      <= '0;
      vetoseen <= 1'b0;
      cnt      <= '0;
      dcnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rise != '0) begin
            pat      <= rise;
            vetoseen <= veto;
            cnt      <= 8'd1;
          end
        end
        S_COLLECT: begin
          pat      <= pat | rise;
          vetoseen <= vetoseen | veto;
          cnt      <= cnt + 8'd1;
        end
        S_COMMIT: begin
          dcnt <= 8'd1;
        end
        S_DEAD: begin
          dcnt <= dcnt + 8'd1;
        end
        default: begin
          pat <= pat;
        end
      endcase
    end
  end

  // Output decode: in COMMIT pick either the pattern bin or the veto counter.
  always_comb begin
    commit_bin  = '0;
    commit_veto = 1'b0;
    busy_nxt    = (state_nxt != S_IDLE);
    if (state == S_COMMIT) begin
      if (vetoseen) begin
        commit_veto = 1'b1;
      end else begin
        commit_bin[pat] = 1'b1;
      end
    end
  end

  // Register the commit strobes and busy so counters see a clean one-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      inc_bin  <= '0;
      inc_veto <= 1'b0;
      busy     <= 1'b0;
    end else begin
      inc_bin  <= commit_bin;
      inc_veto <= commit_veto;
      busy     <= busy_nxt;
    end
  end

  for (genvar p = 0; p < NBINS; p++) begin : g_bin
    hist_counter u_bin (
      .clk   (clk),
      .reset (reset),
      .clr   (resethist),
      .inc   (inc_bin[p]),
      .count (h[p])
    );
  end

  for (genvar t = 0; t < NTRIGOUT; t++) begin : g_trig
    hist_counter u_trig (
      .clk   (clk),
      .reset (reset),
      .clr   (resethist),
      .inc   (trig_rise[t]),
      .count (h_out[t])
    );
  end

  hist_counter u_veto (
    .clk   (clk),
    .reset (reset),
    .clr   (resethist),
    .inc   (inc_veto),
    .count (nvetoed)
  );

endmodule

// File: tb/tb_hit_histogrammer.sv
// Directed bench for hit_histogrammer with WINDOW=4, DEADTIME=2; expectations are hand-derived constants.
// Inputs are driven and outputs sampled on the falling edge, away from the active edge.
// HIST_SATURATE_EN selects the expected overflow result.
module tb_hit_histogrammer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  hits;
  logic        veto;
  logic [1:0]  trig_out;
  logic        resethist;
  logic [31:0] h [16];
  logic [31:0] h_out [2];
  logic [31:0] nvetoed;
  logic        busy;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_h [16];
  logic [31:0] exp_out0;
  logic [31:0] exp_out1;
  logic [31:0] exp_nveto;
  logic [31:0] exp_ovf1;
  logic [31:0] exp_ovf2;

  always #5 clk = ~clk;

  hit_histogrammer #(.NCH(4), .WINDOW(4), .DEADTIME(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .hits      (hits),
    .veto      (veto),
    .trig_out  (trig_out),
    .resethist (resethist),
    .h         (h),
    .h_out     (h_out),
    .nvetoed   (nvetoed),
    .busy      (busy)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s h[%0d]", tag, i), h[i], exp_h[i]);
    end
    chk({tag, " h_out[0]"}, h_out[0], exp_out0);
    chk({tag, " h_out[1]"}, h_out[1], exp_out1);
    chk({tag, " nvetoed"}, nvetoed, exp_nveto);
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 16; i++) exp_h[i] = '0;
    exp_out0  = '0;
    exp_out1  = '0;
    exp_nveto = '0;
  endtask

  initial begin
`ifdef HIST_SATURATE_EN
    exp_ovf1 = 32'hFFFF_FFFF;
    exp_ovf2 = 32'hFFFF_FFFF;
`else
    exp_ovf1 = 32'h0000_0000;
    exp_ovf2 = 32'h0000_0001;
`endif
    clear_exp();
    reset = 1'b1; hits = '0; veto = 1'b0; trig_out = '0; resethist = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk_all("reset");
    chk("reset busy", {31'd0, busy}, 32'd0);

    // Window 1: bit0 rises, bit2 rises two cycles later -> pattern 5.
    hits = 4'b0001;
    tick(2);
    chk("w1 busy collect", {31'd0, busy}, 32'd1);
    hits = 4'b0101;
    tick(3);
    chk("w1 latency h[5]", h[5], 32'd0);
    tick(1);
    exp_h[5] = 32'd1;
    chk_all("w1");
    chk("w1 busy dead", {31'd0, busy}, 32'd1);
    tick(1);
    chk("w1 busy idle", {31'd0, busy}, 32'd0);
    hits = 4'b0000;
    tick(1);

    // Window 2: bit0 only; edges in COMMIT and DEAD dropped; fresh edge then opens window 3.
    hits = 4'b0001;
    tick(4);
    hits = 4'b0011;
    tick(1);
    hits = 4'b0111;
    tick(2);
    exp_h[1] = 32'd1;
    chk_all("dead drop");
    hits = 4'b1111;
    tick(6);
    exp_h[8] = 32'd1;
    chk_all("after dead");
    chk("after dead busy", {31'd0, busy}, 32'd1);
    tick(1);
    chk("after dead idle", {31'd0, busy}, 32'd0);
    hits = 4'b0000;
    tick(2);

    // Vetoed window with pattern 15.
    hits = 4'b1111;
    tick(1);
    veto = 1'b1;
    tick(1);
    veto = 1'b0;
    hits = 4'b0000;
    tick(8);
    exp_nveto = 32'd1;
    chk_all("veto");

    // Trigger-output edges: three rises on bit1, one held high 5 cycles.
    trig_out = 2'b10; tick(1);
    trig_out = 2'b00; tick(1);
    trig_out = 2'b10; tick(5);
    trig_out = 2'b00; tick(1);
    trig_out = 2'b10; tick(1);
    trig_out = 2'b00; tick(2);
    exp_out1 = 32'd3;
    chk_all("trig1");
    trig_out = 2'b11; tick(1);
    trig_out = 2'b00; tick(2);
    exp_out0 = 32'd1;
    exp_out1 = 32'd4;
    chk_all("trig both");

    // Seven windows of pattern 3.
    for (int k = 0; k < 7; k++) begin
      hits = 4'b0011;
      tick(1);
      hits = 4'b0000;
      tick(8);
    end
    exp_h[3] = 32'd7;
    chk_all("seven p3");

    // resethist in the COMMIT cycle of an eighth pattern-3 window, plus a trig edge in the same cycle.
    hits = 4'b0011;
    tick(1);
    hits = 4'b0000;
    tick(3);
    resethist = 1'b1;
    trig_out  = 2'b01;
    tick(1);
    resethist = 1'b0;
    trig_out  = 2'b00;
    tick(6);
    clear_exp();
    exp_h[3] = 32'd1;
    exp_out0 = 32'd1;
    chk_all("resethist");

    // Reset in the middle of a window: everything cleared, window not counted.
    hits = 4'b0100;
    tick(2);
    reset = 1'b1;
    hits  = 4'b0000;
    tick(2);
    reset = 1'b0;
    tick(8);
    clear_exp();
    chk_all("reset midwin");
    chk("reset midwin busy", {31'd0, busy}, 32'd0);

    // Overflow of bin 2.
    force dut.g_bin[2].u_bin.count = 32'hFFFF_FFFF;
    tick(1);
    release dut.g_bin[2].u_bin.count;
    tick(1);
    chk("preload h[2]", h[2], 32'hFFFF_FFFF);
    hits = 4'b0010;
    tick(1);
    hits = 4'b0000;
    tick(8);
    exp_h[2] = exp_ovf1;
    chk_all("overflow 1");
    hits = 4'b0010;
    tick(1);
    hits = 4'b0000;
    tick(8);
    exp_h[2] = exp_ovf2;
    chk_all("overflow 2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
